// File: rtl/mips_pkg.sv
// Shared types for the MIPS III pipeline: the machine word, the fetch FSM states and the canonical NOP.
package mips_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {RUN, STALL_PEND, HALTED} fetch_state_e;
  localparam word_t NOP_WORD = 32'h0000_0000;  // sll $0,$0,0
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. One-cycle capture of the fetched word; hold freezes it, bubble (dominant) inserts a NOP.
import mips_pkg::*;

module if_id_reg #(
  parameter word_t NOP_INSTR = NOP_WORD
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  hold,
  input  logic  bubble,
  input  word_t fetch_pc,
  input  word_t fetch_ir,
  output logic  id_valid,
  output word_t id_instr,
  output word_t id_pc,
  output word_t id_pc_plus4,
  output logic  id_addr_err
);

  logic misaligned;
  assign misaligned = (fetch_pc[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid    <= 1'b0;
      id_instr    <= NOP_INSTR;
      id_pc       <= '0;
      id_pc_plus4 <= '0;
      id_addr_err <= 1'b0;
    end else if (bubble) begin
      id_valid    <= 1'b0;
      id_instr    <= NOP_INSTR;
      id_addr_err <= 1'b0;
    end else if (!hold) begin
      // A misaligned fetch still travels down as a valid slot so decode can raise AdEL.
      id_valid    <= 1'b1;
      id_instr    <= misaligned ? NOP_INSTR : fetch_ir;
      id_pc       <= fetch_pc;
      id_pc_plus4 <= fetch_pc + 32'd4;
      id_addr_err <= misaligned;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, addresses the combinational imem and fills IF/ID one cycle later.
// Stall holds PC and IF/ID; a redirect seen during a stall is parked and applied on release.
import mips_pkg::*;

module fetch_stage #(
  parameter word_t RESET_PC   = 32'h0000_0000,
  parameter word_t EXC_VECTOR = 32'h0000_0080,
  parameter word_t NOP_INSTR  = NOP_WORD
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  stall_i,
  input  logic  redirect_valid,
  input  word_t redirect_target,
  input  logic  exc_valid,
  input  logic  halt_i,
  output word_t imem_addr,
  input  word_t imem_ir,
  output logic  id_valid,
  output word_t id_instr,
  output word_t id_pc,
  output word_t id_pc_plus4,
  output logic  id_addr_err,
  output logic  halted
);

  fetch_state_e state, state_nxt;
  word_t        pc, pc_nxt;
  word_t        pend_target, pend_target_nxt;
  logic         pend_valid, pend_valid_nxt;
  logic         ifid_hold, ifid_bubble;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (exc_valid)                     state_nxt = RUN;
        else if (stall_i && redirect_valid) state_nxt = STALL_PEND;
        else if (!stall_i && halt_i)       state_nxt = HALTED;
      end
      STALL_PEND: begin
        if (exc_valid || !stall_i) state_nxt = RUN;
      end
      default: state_nxt = state;
    endcase
  end

  // Datapath controls; HALTED falls through to the all-hold defaults.
  always_comb begin
    pc_nxt          = pc;
    pend_target_nxt = pend_target;
    pend_valid_nxt  = pend_valid;
    ifid_hold       = 1'b1;
    ifid_bubble     = 1'b0;
    case (state)
      RUN: begin
        if (exc_valid) begin
          pc_nxt         = EXC_VECTOR;
          ifid_bubble    = 1'b1;
          pend_valid_nxt = 1'b0;
        end else if (stall_i) begin
          if (redirect_valid) begin
            pend_target_nxt = redirect_target;
            pend_valid_nxt  = 1'b1;
          end
        end else if (halt_i) begin
          ifid_bubble = 1'b1;
        end else begin
          // The current fetch is the delay slot and is captured either way.
          ifid_hold = 1'b0;
          pc_nxt    = redirect_valid ? redirect_target : pc + 32'd4;
        end
      end
      STALL_PEND: begin
        if (exc_valid) begin
          pc_nxt         = EXC_VECTOR;
          ifid_bubble    = 1'b1;
          pend_valid_nxt = 1'b0;
        end else if (stall_i) begin
          if (redirect_valid) pend_target_nxt = redirect_target;
        end else begin
          ifid_hold      = 1'b0;
          pc_nxt         = pend_valid ? pend_target : pc + 32'd4;
          pend_valid_nxt = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    imem_addr = pc;
    halted    = (state == HALTED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      pend_target <= '0;
      pend_valid  <= 1'b0;
    end else begin
      pc          <= pc_nxt;
      pend_target <= pend_target_nxt;
      pend_valid  <= pend_valid_nxt;
    end
  end

  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk         (clk),
    .rst_n       (rst_n),
    .hold        (ifid_hold),
    .bubble      (ifid_bubble),
    .fetch_pc    (pc),
    .fetch_ir    (imem_ir),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_pc_plus4 (id_pc_plus4),
    .id_addr_err (id_addr_err)
  );

endmodule
